fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch-stage sequencer that drives the instruction-memory request interface and produces the d-inputs of the fetch/decode pipeline register (PC_next, instr, flush).
- The fetch/decode register has no enable and captures every cycle. This block implements decode stalls by re-presenting the values the register already holds.
- It inserts NOP bubbles on memory wait states and flushes on branch redirects.
- It sits between the PC/imem and the fetch/decode register; the decode hazard logic drives stall and a later stage drives redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INSTR, 32'h0000_0000, encoding presented as a bubble.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  decode hazard; fetch/decode contents must be held.
- redirect  in  1  taken branch/jump; fetch restarts at redirect_pc.
- redirect_pc  in  32  redirect target (word aligned).
- imem_req  out  1  request valid; imem_addr must be held stable until imem_ready.
- imem_addr  out  32  fetch address (register req_addr).
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  fetched instruction.
- fede_pc_next  out  32  to fetch/decode PC_next input.
- fede_instr  out  32  to fetch/decode instr input.
- fede_flush  out  1  to fetch/decode flush input.

Behaviour:
- Registers:
  - state in {FETCH, SKID, DRAIN}
  - req_addr
  - target (pending redirect address)
  - skid_instr/skid_pc (1-entry skid buffer)
  - last_instr/last_pc (shadow of last presented values)
- Reset (rst_n=0 at edge):
  - state=FETCH, req_addr=RESET_PC, skid cleared, last_instr=NOP_INSTR, last_pc=RESET_PC.
  - While rst_n=0, outputs are imem_req=0, fede_instr=NOP_INSTR, fede_pc_next=RESET_PC, fede_flush=0.
  - Reset mid-request abandons it; imem resets on the same rst_n.
- imem_req=1 in FETCH and DRAIN, 0 in SKID. imem_addr=req_addr always.
- Presented values (fede_instr, fede_pc_next) are combinational, chosen by first match:
  1. redirect: NOP_INSTR, redirect_pc; fede_flush=1 (only case it is 1).
  2. stall: last_instr, last_pc.
  3. state SKID: skid_instr, skid_pc.
  4. FETCH & imem_ready: imem_rdata, req_addr+4.
  5. otherwise: NOP_INSTR, req_addr (bubble).
- last_* take the presented values every cycle.
- PC arithmetic is 32-bit modulo, wraps 32'hFFFF_FFFC -> 0. No alignment checking.
- FETCH transitions:
  - ready & !stall & !redirect: req_addr+=4, stay FETCH. Back-to-back fetch gives one instruction per cycle with a 0-wait imem.
  - ready & stall & !redirect: skid <= {imem_rdata, req_addr+4}, req_addr+=4, go SKID.
  - redirect & ready: discard response, req_addr<=redirect_pc, stay FETCH.
  - redirect & !ready: target<=redirect_pc, go DRAIN (address must stay stable).
  - !ready, no redirect: hold.
- SKID transitions:
  - redirect: clear skid, req_addr<=redirect_pc, go FETCH.
  - !stall: skid presented this cycle, clear, go FETCH; the request issues next cycle.
  - stall: hold.
- DRAIN transitions:
  - The response for the old req_addr is discarded; the presented value is a bubble or held (stall).
  - redirect: target<=redirect_pc, and if ready also go FETCH with req_addr<=redirect_pc.
  - ready, no redirect: req_addr<=target, go FETCH.
- Redirect priority: redirect beats stall and beats skid; stall beats an arriving response. No instruction is lost or duplicated across stall.
- Latency: the instruction at address A reaches fede_instr in the cycle imem_ready is returned for A, and lands in fetch/decode on the following edge.

Test Plan:
- Reset then 0-wait imem returning addr as data: fede_instr 0,4,8,... and fede_pc_next 4,8,12,... on consecutive cycles; imem_addr 0,4,8.
- imem_ready delayed 2 cycles per request: 2 NOP bubbles with fede_pc_next=req_addr between each instruction; imem_addr stable while imem_req=1 & !imem_ready.
- Stall 3 cycles while response for 0x10 arrives: fede_instr=last_instr for 3 cycles with imem_req=0 (SKID); on release, fede_instr=data@0x10, fede_pc_next=0x14; next request addresses 0x14.
- Redirect to 0x200 while request for 0x40 outstanding: fede_flush=1 for one cycle, NOP presented; 0x40 response discarded; next imem_addr=0x200; first instruction presents pc_next 0x204.
- Redirect and stall in same cycle with ready=1: flush=1, response discarded, imem_addr=redirect_pc next cycle. Also check wrap: req_addr 0xFFFF_FFFC yields pc_next 0.
- rst_n low mid-DRAIN: next cycle state FETCH, imem_addr=RESET_PC, fede_instr=NOP_INSTR, skid empty.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
// The address is held stable by the master until imem_ready completes the request.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives imem requests and the d-inputs of the enable-less
// fetch/decode register, re-presenting held values on stall and bubbling on waits.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    fetch_ctrl_if.master       imem,
    output logic [31:0]        fede_pc_next,
    output logic [31:0]        fede_instr,
    output logic               fede_flush
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SKID  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, stateNext;
    logic [31:0] reqAddr, reqAddrNext;
    logic [31:0] target, targetNext;
    logic [31:0] skidInstr, skidInstrNext;
    logic [31:0] skidPc, skidPcNext;
    logic [31:0] lastInstr, lastPc;
    logic [31:0] reqAddrPlus4;

    assign reqAddrPlus4   = reqAddr + 32'd4;
    assign imem.imem_addr = reqAddr;
    assign imem.imem_req  = rst_n && (state != SKID);

    // Presented values, first match wins; reset forces a quiet bubble.
    always_comb begin
        fede_instr   = NOP_INSTR;
        fede_pc_next = reqAddr;
        fede_flush   = 1'b0;
        if (!rst_n) begin
            fede_pc_next = RESET_PC;
        end else if (redirect) begin
            fede_pc_next = redirect_pc;
            fede_flush   = 1'b1;
        end else if (stall) begin
            fede_instr   = lastInstr;
            fede_pc_next = lastPc;
        end else if (state == SKID) begin
            fede_instr   = skidInstr;
            fede_pc_next = skidPc;
        end else if (state == FETCH && imem.imem_ready) begin
            fede_instr   = imem.imem_rdata;
            fede_pc_next = reqAddrPlus4;
        end
    end

    always_comb begin
        stateNext     = state;
        reqAddrNext   = reqAddr;
        targetNext    = target;
        skidInstrNext = skidInstr;
        skidPcNext    = skidPc;
        unique case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem.imem_ready) begin
                        reqAddrNext = redirect_pc;
                    end else begin
                        // Outstanding request must complete at the old address first.
                        targetNext = redirect_pc;
                        stateNext  = DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    reqAddrNext = reqAddrPlus4;
                    if (stall) begin
                        skidInstrNext = imem.imem_rdata;
                        skidPcNext    = reqAddrPlus4;
                        stateNext     = SKID;
                    end
                end
            end
            SKID: begin
                if (redirect) begin
                    skidInstrNext = '0;
                    skidPcNext    = '0;
                    reqAddrNext   = redirect_pc;
                    stateNext     = FETCH;
                end else if (!stall) begin
                    skidInstrNext = '0;
                    skidPcNext    = '0;
                    stateNext     = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    targetNext = redirect_pc;
                    if (imem.imem_ready) begin
                        reqAddrNext = redirect_pc;
                        stateNext   = FETCH;
                    end
                end else if (imem.imem_ready) begin
                    reqAddrNext = target;
                    stateNext   = FETCH;
                end
            end
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            reqAddr   <= RESET_PC;
            target    <= RESET_PC;
            skidInstr <= '0;
            skidPc    <= '0;
            lastInstr <= NOP_INSTR;
            lastPc    <= RESET_PC;
        end else begin
            state     <= stateNext;
            reqAddr   <= reqAddrNext;
            target    <= targetNext;
            skidInstr <= skidInstrNext;
            skidPc    <= skidPcNext;
            lastInstr <= fede_instr;
            lastPc    <= fede_pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each task drives a scenario cycle by cycle and
// compares {imem_req, imem_addr, fede_instr, fede_pc_next, fede_flush}.
module tb_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] fedePcNext;
    logic [31:0] fedeInstr;
    logic        fedeFlush;
    int          nChecks = 0;
    int          nPass = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirectPc),
        .imem         (bus.master),
        .fede_pc_next (fedePcNext),
        .fede_instr   (fedeInstr),
        .fede_flush   (fedeFlush)
    );

    always #5 clk = ~clk;

    wire [97:0] obs = {bus.imem_req, bus.imem_addr, fedeInstr, fedePcNext, fedeFlush};

    // One cycle of stimulus: inputs change just after the edge, outputs settle before the next.
    task automatic drive(input logic rn, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        rst_n              = rn;
        stall              = st;
        redirect           = rd;
        redirectPc         = rpc;
        bus.imem_ready     = rdy;
        bus.imem_rdata     = rdata;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'hDEAD_BEEF);
        nChecks++;
        if (obs !== {1'b0, 32'h0, NOP, RST_PC, 1'b0})
            $display("FAIL reset_hold got=%h want=%h", obs, {1'b0, 32'h0, NOP, RST_PC, 1'b0});
        else nPass++;
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0000 | a);
            nChecks++;
            if (obs !== {1'b1, a, 32'hC000_0000 | a, a + 32'd4, 1'b0})
                $display("FAIL zero_wait[%0d] got=%h want=%h", i, obs,
                         {1'b1, a, 32'hC000_0000 | a, a + 32'd4, 1'b0});
            else nPass++;
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
            nChecks++;
            if (obs !== {1'b1, 32'h0C, NOP, 32'h0C, 1'b0})
                $display("FAIL wait_bubble[%0d] got=%h want=%h", i, obs, {1'b1, 32'h0C, NOP, 32'h0C, 1'b0});
            else nPass++;
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_000C);
        nChecks++;
        if (obs !== {1'b1, 32'h0C, 32'hC000_000C, 32'h10, 1'b0})
            $display("FAIL wait_done got=%h want=%h", obs, {1'b1, 32'h0C, 32'hC000_000C, 32'h10, 1'b0});
        else nPass++;
    endtask

    task automatic test_stall_skid();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC000_0010);
        nChecks++;
        if (obs !== {1'b1, 32'h10, 32'hC000_000C, 32'h10, 1'b0})
            $display("FAIL stall_arrive got=%h want=%h", obs, {1'b1, 32'h10, 32'hC000_000C, 32'h10, 1'b0});
        else nPass++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
            nChecks++;
            if (obs !== {1'b0, 32'h14, 32'hC000_000C, 32'h10, 1'b0})
                $display("FAIL stall_skid[%0d] got=%h want=%h", i, obs, {1'b0, 32'h14, 32'hC000_000C, 32'h10, 1'b0});
            else nPass++;
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        nChecks++;
        if (obs !== {1'b0, 32'h14, 32'hC000_0010, 32'h14, 1'b0})
            $display("FAIL skid_release got=%h want=%h", obs, {1'b0, 32'h14, 32'hC000_0010, 32'h14, 1'b0});
        else nPass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0014);
        nChecks++;
        if (obs !== {1'b1, 32'h14, 32'hC000_0014, 32'h18, 1'b0})
            $display("FAIL after_skid got=%h want=%h", obs, {1'b1, 32'h14, 32'hC000_0014, 32'h18, 1'b0});
        else nPass++;
    endtask

    task automatic test_redirect_drain();
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'hC000_0018);
        nChecks++;
        if (obs !== {1'b1, 32'h18, NOP, 32'h40, 1'b1})
            $display("FAIL redir_ready got=%h want=%h", obs, {1'b1, 32'h18, NOP, 32'h40, 1'b1});
        else nPass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        nChecks++;
        if (obs !== {1'b1, 32'h40, NOP, 32'h40, 1'b0})
            $display("FAIL redir_newaddr got=%h want=%h", obs, {1'b1, 32'h40, NOP, 32'h40, 1'b0});
        else nPass++;
        drive(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'hDEAD_BEEF);
        nChecks++;
        if (obs !== {1'b1, 32'h40, NOP, 32'h200, 1'b1})
            $display("FAIL redir_pending got=%h want=%h", obs, {1'b1, 32'h40, NOP, 32'h200, 1'b1});
        else nPass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        nChecks++;
        if (obs !== {1'b1, 32'h40, NOP, 32'h40, 1'b0})
            $display("FAIL drain_hold got=%h want=%h", obs, {1'b1, 32'h40, NOP, 32'h40, 1'b0});
        else nPass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0040);
        nChecks++;
        if (obs !== {1'b1, 32'h40, NOP, 32'h40, 1'b0})
            $display("FAIL drain_discard got=%h want=%h", obs, {1'b1, 32'h40, NOP, 32'h40, 1'b0});
        else nPass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0200);
        nChecks++;
        if (obs !== {1'b1, 32'h200, 32'hC000_0200, 32'h204, 1'b0})
            $display("FAIL redir_first got=%h want=%h", obs, {1'b1, 32'h200, 32'hC000_0200, 32'h204, 1'b0});
        else nPass++;
    endtask

    task automatic test_redirect_stall_wrap();
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hC000_0204);
        nChecks++;
        if (obs !== {1'b1, 32'h204, NOP, 32'hFFFF_FFFC, 1'b1})
            $display("FAIL redir_stall got=%h want=%h", obs, {1'b1, 32'h204, NOP, 32'hFFFF_FFFC, 1'b1});
        else nPass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        nChecks++;
        if (obs !== {1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 1'b0})
            $display("FAIL wrap_pc got=%h want=%h", obs, {1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 1'b0});
        else nPass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        nChecks++;
        if (obs !== {1'b1, 32'h0, NOP, 32'h0, 1'b0})
            $display("FAIL wrap_addr got=%h want=%h", obs, {1'b1, 32'h0, NOP, 32'h0, 1'b0});
        else nPass++;
    endtask

    task automatic test_reset_in_drain();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0000);
        nChecks++;
        if (obs !== {1'b1, 32'h0, 32'hC000_0000, 32'h4, 1'b0})
            $display("FAIL pre_drain got=%h want=%h", obs, {1'b1, 32'h0, 32'hC000_0000, 32'h4, 1'b0});
        else nPass++;
        drive(1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        nChecks++;
        if (obs !== {1'b1, 32'h4, NOP, 32'h4, 1'b0})
            $display("FAIL in_drain got=%h want=%h", obs, {1'b1, 32'h4, NOP, 32'h4, 1'b0});
        else nPass++;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0004);
        nChecks++;
        if (obs !== {1'b0, 32'h4, NOP, RST_PC, 1'b0})
            $display("FAIL drain_rst_low got=%h want=%h", obs, {1'b0, 32'h4, NOP, RST_PC, 1'b0});
        else nPass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        nChecks++;
        if (obs !== {1'b1, RST_PC, NOP, RST_PC, 1'b0})
            $display("FAIL post_rst got=%h want=%h", obs, {1'b1, RST_PC, NOP, RST_PC, 1'b0});
        else nPass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0000);
        nChecks++;
        if (obs !== {1'b1, RST_PC, 32'hC000_0000, 32'h4, 1'b0})
            $display("FAIL post_rst_fetch got=%h want=%h", obs, {1'b1, RST_PC, 32'hC000_0000, 32'h4, 1'b0});
        else nPass++;
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirectPc     = 32'h0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_skid();
        test_redirect_drain();
        test_redirect_stall_wrap();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
